// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, blank code and active-low hex table {g,f,e,d,c,b,a}
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t HEX_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble (nib) to active-low segment code (seg)
module seg7_hex_decode import seg7_pkg::*; (
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = HEX_TABLE[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit multiplexed 7-seg driver; clk/rst_n, data_i/dp_i/blank_i/load_i/lz_en_i in, seg_o/dp_o/an_o/frame_o out
module seg7_scan_driver import seg7_pkg::*; #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  lz_en_i,
  input  logic                  load_i,
  output seg_t                  seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0] pend_dp, pend_blank, act_dp, act_blank, hz;
  logic pend_flag, tick, wrap, sup;
  logic [3:0] nib;
  seg_t hex;
  assign tick = cnt == CW'(DIV - 1);
  assign wrap = tick && idx == IW'(DIGITS - 1);
  assign frame_o = rst_n && wrap;
  // hz[k]: every nibble from the top digit down to k is zero
  for (genvar g = 0; g < DIGITS; g++) begin : g_hz
    assign hz[g] = ~|act_data[4*DIGITS-1:4*g];
  end
  assign nib = act_data[{idx, 2'b00} +: 4];
  assign sup = lz_en_i && idx != '0 && !act_blank[idx] && hz[idx];
  seg7_hex_decode u_dec (.nib(nib), .seg(hex));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      pend_flag  <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      seg_o      <= SEG_BLANK;
      dp_o       <= 1'b1;
      an_o       <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      if (load_i) begin
        pend_data  <= data_i;
        pend_dp    <= dp_i;
        pend_blank <= blank_i;
      end
      // a load landing on the wrap bypasses pending so it shows from this frame
      pend_flag <= wrap ? 1'b0 : (load_i || pend_flag);
      if (wrap && (load_i || pend_flag)) begin
        act_data  <= load_i ? data_i : pend_data;
        act_dp    <= load_i ? dp_i : pend_dp;
        act_blank <= load_i ? blank_i : pend_blank;
      end
      an_o  <= ~(DIGITS'(1) << idx);
      seg_o <= act_blank[idx] || sup ? SEG_BLANK : hex;
      dp_o  <= act_blank[idx] || !act_dp[idx];
    end
  end
endmodule
